binary_frame_writer: RTL and testbench
======================================

BINARY_FRAME_WRITER -- requirements
Module: binary_frame_writer

Interface
REQ-001 Param IMG_WIDTH, default 640, pixels per line.
REQ-002 Param IMG_HEIGHT, default 480, lines per frame.
REQ-003 Param THRESHOLD, default 128, gray level at/above which a pixel is white.
REQ-004 N = IMG_WIDTH*IMG_HEIGHT; ADDR_W = $clog2(N).
REQ-005 Single clock and reset: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-006 pix_valid  in  1  upstream pixel beat valid.
REQ-007 pix_ready  out  1  block accepts beat; beat accepted when pix_valid && pix_ready.
REQ-008 pix_data  in  8  grayscale pixel, raster order.
REQ-009 pix_sop  in  1  beat is pixel (0,0) of a frame.
REQ-010 pix_eop  in  1  beat is last pixel of a frame.
REQ-011 bram_we  out  1  binary-frame BRAM write enable.
REQ-012 bram_waddr  out  ADDR_W  write address = y*IMG_WIDTH+x.
REQ-013 bram_wdata  out  2  pixel code: 2'b00 black, 2'b01 white.
REQ-014 valid_to_read  out  1  level; complete binary frame in BRAM, detector may scan.
REQ-015 detection_valid  in  1  one-cycle pulse from detector: scan finished, buffer released.
REQ-016 frame_error  out  1  sticky malformed-frame flag.
REQ-017 frames_done  out  8  count of frames handed off.

Function
REQ-018 States SHALL be IDLE, WRITE, HANDOFF; reset state IDLE.
REQ-019 pix_ready SHALL be 1 in IDLE and WRITE, 0 in HANDOFF (no BRAM writes while detector reads/marks).
REQ-020 Write path SHALL be registered: accepted beat at cycle t -> bram_we=1, bram_waddr, bram_wdata at t+1; bram_we=0 otherwise.
REQ-021 bram_wdata SHALL be 2'b01 if pix_data >= THRESHOLD (unsigned), else 2'b00; codes 2'b10/2'b11 never written.
REQ-022 IDLE: accepted beat without sop SHALL be discarded (no write); beat with sop and not eop SHALL write addr 0, set pixel counter to 1, go WRITE.
REQ-023 WRITE: accepted beat without sop SHALL write addr = counter, counter+1.
REQ-024 WRITE: beat with eop and counter == N-1 SHALL write addr N-1 and go HANDOFF.
REQ-025 WRITE: beat with eop and counter != N-1 (short frame) SHALL write nothing, set frame_error, go IDLE.
REQ-026 WRITE: beat at counter == N-1 without eop (long frame) SHALL write nothing, set frame_error, go IDLE.
REQ-027 WRITE: beat with sop (restart) SHALL set frame_error, write addr 0, counter=1, stay WRITE.
REQ-028 Any beat with sop and eop together SHALL set frame_error, write nothing, go IDLE (sop priority otherwise irrelevant).
REQ-029 valid_to_read SHALL rise on the cycle HANDOFF is entered (same cycle the final write is issued is permitted, since the write lands at t+1 and detector reads start later) and frames_done SHALL increment (mod 256) on HANDOFF entry.
REQ-030 HANDOFF: detection_valid=1 SHALL clear valid_to_read next cycle and return to IDLE; detection_valid in IDLE/WRITE SHALL be ignored.
REQ-031 frame_error SHALL stay 1 until reset.
REQ-032 Counter width ADDR_W; never wraps past N-1 (REQ-026 guards).

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, counter 0, bram_we 0, bram_waddr 0, bram_wdata 0, valid_to_read 0, frame_error 0, frames_done 0; pix_ready 1 after release.
REQ-034 Reset mid-WRITE or mid-HANDOFF SHALL abandon the frame; no write issued in the cycle after release unless a new accepted beat occurred.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, N=8, THRESHOLD=128)
REQ-035 8 beats, sop on first, eop on last, data 0,127,128,255,10,200,128,0 -> writes addr 0..7 codes 0,0,1,1,0,1,1,0; valid_to_read=1, frames_done=1, pix_ready=0.
REQ-036 In HANDOFF, pulse detection_valid -> valid_to_read=0 next cycle, pix_ready=1; second good frame -> frames_done=2.
REQ-037 sop then eop on 5th beat -> 4 writes only, frame_error=1, state IDLE, valid_to_read stays 0.
REQ-038 3 beats then new sop, then 8-beat good frame -> frame_error=1, addr restarts at 0, handoff occurs, valid_to_read=1.
REQ-039 Beats without sop in IDLE, pix_valid gaps mid-frame -> no writes in IDLE; gaps produce no writes; addresses contiguous.
REQ-040 Assert rst_n low at beat 4 and in HANDOFF -> all outputs reset values within same cycle; no stale write after release.

Source files
------------

// File: rtl/binary_frame_writer_if.sv
// Pixel stream, binary-frame BRAM write port and detector handoff signals
// for binary_frame_writer.
interface binary_frame_writer_if #(
   parameter int unsigned ADDR_W = 19
);
   logic              pix_valid;
   logic              pix_ready;
   logic [7:0]        pix_data;
   logic              pix_sop;
   logic              pix_eop;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_waddr;
   logic [1:0]        bram_wdata;
   logic              valid_to_read;
   logic              detection_valid;
   logic              frame_error;
   logic [7:0]        frames_done;

   modport master (
      output pix_valid, pix_data, pix_sop, pix_eop, detection_valid,
      input  pix_ready, bram_we, bram_waddr, bram_wdata,
             valid_to_read, frame_error, frames_done
   );

   modport slave (
      input  pix_valid, pix_data, pix_sop, pix_eop, detection_valid,
      output pix_ready, bram_we, bram_waddr, bram_wdata,
             valid_to_read, frame_error, frames_done
   );
endinterface

// File: rtl/binary_frame_writer.sv
// Thresholds a raster grayscale stream into a 2-bit-per-pixel BRAM frame and
// holds the buffer for a downstream detector until it signals release.
module binary_frame_writer #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter int unsigned THRESHOLD  = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   binary_frame_writer_if.slave  bus
);
   localparam int unsigned N      = IMG_WIDTH * IMG_HEIGHT;
   localparam int unsigned ADDR_W = $clog2(N);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HANDOFF} state_t;

   state_t            r_state,  w_state_nx;
   logic [ADDR_W-1:0] r_cnt,    w_cnt_nx;
   logic              r_we,     w_we_nx;
   logic [ADDR_W-1:0] r_waddr,  w_waddr_nx;
   logic [1:0]        r_wdata,  w_wdata_nx;
   logic              r_vtr,    w_vtr_nx;
   logic              r_err,    w_err_nx;
   logic [7:0]        r_done,   w_done_nx;
   logic              r_ready,  w_ready_nx;

   logic              w_accept;
   logic [1:0]        w_code;
   logic              w_last;

   assign w_accept = bus.pix_valid && r_ready;
   assign w_code   = ({1'b0, bus.pix_data} >= 9'(THRESHOLD)) ? 2'b01 : 2'b00;
   assign w_last   = (r_cnt == ADDR_W'(N - 1));

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= 2'b00;
         r_vtr   <= 1'b0;
         r_err   <= 1'b0;
         r_done  <= 8'd0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_we    <= w_we_nx;
         r_waddr <= w_waddr_nx;
         r_wdata <= w_wdata_nx;
         r_vtr   <= w_vtr_nx;
         r_err   <= w_err_nx;
         r_done  <= w_done_nx;
         r_ready <= w_ready_nx;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_we_nx    = 1'b0;
      w_waddr_nx = r_waddr;
      w_wdata_nx = r_wdata;
      w_vtr_nx   = r_vtr;
      w_err_nx   = r_err;
      w_done_nx  = r_done;

      unique case (r_state)
         S_IDLE: begin
            if (w_accept && bus.pix_sop) begin
               if (bus.pix_eop) begin
                  w_err_nx = 1'b1;
               end else begin
                  w_we_nx    = 1'b1;
                  w_waddr_nx = '0;
                  w_wdata_nx = w_code;
                  w_cnt_nx   = ADDR_W'(1);
                  w_state_nx = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (w_accept) begin
               if (bus.pix_sop && bus.pix_eop) begin
                  w_err_nx   = 1'b1;
                  w_cnt_nx   = '0;
                  w_state_nx = S_IDLE;
               end else if (bus.pix_sop) begin
                  // Restart: flag the broken frame but keep capturing the new one
                  w_err_nx   = 1'b1;
                  w_we_nx    = 1'b1;
                  w_waddr_nx = '0;
                  w_wdata_nx = w_code;
                  w_cnt_nx   = ADDR_W'(1);
               end else if (bus.pix_eop && w_last) begin
                  w_we_nx    = 1'b1;
                  w_waddr_nx = r_cnt;
                  w_wdata_nx = w_code;
                  w_cnt_nx   = '0;
                  w_vtr_nx   = 1'b1;
                  w_done_nx  = r_done + 8'd1;
                  w_state_nx = S_HANDOFF;
               end else if (bus.pix_eop || w_last) begin
                  w_err_nx   = 1'b1;
                  w_cnt_nx   = '0;
                  w_state_nx = S_IDLE;
               end else begin
                  w_we_nx    = 1'b1;
                  w_waddr_nx = r_cnt;
                  w_wdata_nx = w_code;
                  w_cnt_nx   = r_cnt + ADDR_W'(1);
               end
            end
         end
         S_HANDOFF: begin
            if (bus.detection_valid) begin
               w_vtr_nx   = 1'b0;
               w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase

      w_ready_nx = (w_state_nx != S_HANDOFF);
   end

   assign bus.pix_ready     = r_ready;
   assign bus.bram_we       = r_we;
   assign bus.bram_waddr    = r_waddr;
   assign bus.bram_wdata    = r_wdata;
   assign bus.valid_to_read = r_vtr;
   assign bus.frame_error   = r_err;
   assign bus.frames_done   = r_done;
endmodule

// File: tb/tb_binary_frame_writer.sv
// Directed self-checking bench for binary_frame_writer on a 4x2 frame.
module tb_binary_frame_writer;
   localparam int unsigned AW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   binary_frame_writer_if #(.ADDR_W(AW)) bus ();

   binary_frame_writer #(
      .IMG_WIDTH (4),
      .IMG_HEIGHT(2),
      .THRESHOLD (128)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic [AW-1:0] wa_q[$];
   logic [1:0]    wd_q[$];

   logic [7:0] pix_tab  [8] = '{8'd0, 8'd127, 8'd128, 8'd255, 8'd10, 8'd200, 8'd128, 8'd0};
   logic [1:0] code_tab [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};

   // Write log, captured just after each rising edge
   always @(posedge clk) begin
      #1;
      if (bus.bram_we) begin
         wa_q.push_back(bus.bram_waddr);
         wd_q.push_back(bus.bram_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic beat(input logic [7:0] d, input logic s, input logic e);
      bus.pix_valid = 1'b1;
      bus.pix_data  = d;
      bus.pix_sop   = s;
      bus.pix_eop   = e;
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.pix_sop   = 1'b0;
      bus.pix_eop   = 1'b0;
   endtask

   task automatic good_frame();
      for (int i = 0; i < 8; i++) beat(pix_tab[i], i == 0, i == 7);
   endtask

   task automatic release_buf();
      bus.detection_valid = 1'b1;
      @(negedge clk);
      bus.detection_valid = 1'b0;
   endtask

   task automatic reset_dut();
      bus.pix_valid       = 1'b0;
      bus.detection_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      bus.pix_valid = 1'b0; bus.pix_data = 8'd0; bus.pix_sop = 1'b0;
      bus.pix_eop = 1'b0;   bus.detection_valid = 1'b0;
      reset_dut();

      // Reset state
      check("rst_ready", 32'(bus.pix_ready), 1);
      check("rst_vtr",   32'(bus.valid_to_read), 0);
      check("rst_err",   32'(bus.frame_error), 0);
      check("rst_done",  32'(bus.frames_done), 0);
      check("rst_we",    32'(bus.bram_we), 0);

      // Good frame with threshold boundary values
      base = wa_q.size();
      good_frame();
      check("f1_nwr", 32'(wa_q.size() - base), 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("f1_addr%0d", i), 32'(wa_q[base+i]), 32'(i));
         check($sformatf("f1_code%0d", i), 32'(wd_q[base+i]), 32'(code_tab[i]));
      end
      check("f1_vtr",   32'(bus.valid_to_read), 1);
      check("f1_done",  32'(bus.frames_done), 1);
      check("f1_ready", 32'(bus.pix_ready), 0);
      check("f1_err",   32'(bus.frame_error), 0);

      // Beat offered during handoff is not taken
      base = wa_q.size();
      beat(8'd255, 1'b1, 1'b0);
      @(negedge clk);
      check("ho_nowr", 32'(wa_q.size() - base), 0);
      check("ho_vtr",  32'(bus.valid_to_read), 1);

      release_buf();
      check("rel_vtr",   32'(bus.valid_to_read), 0);
      check("rel_ready", 32'(bus.pix_ready), 1);

      good_frame();
      check("f2_done", 32'(bus.frames_done), 2);
      check("f2_vtr",  32'(bus.valid_to_read), 1);
      release_buf();

      // Short frame: eop on 5th beat
      base = wa_q.size();
      beat(8'd10, 1'b1, 1'b0);
      beat(8'd200, 1'b0, 1'b0);
      beat(8'd128, 1'b0, 1'b0);
      beat(8'd0, 1'b0, 1'b0);
      beat(8'd50, 1'b0, 1'b1);
      @(negedge clk);
      check("sh_nwr",  32'(wa_q.size() - base), 4);
      check("sh_code1", 32'(wd_q[base+1]), 1);
      check("sh_err",  32'(bus.frame_error), 1);
      check("sh_vtr",  32'(bus.valid_to_read), 0);
      check("sh_done", 32'(bus.frames_done), 2);
      beat(8'd255, 1'b0, 1'b0);
      @(negedge clk);
      check("sh_idle", 32'(wa_q.size() - base), 4);

      // Restart mid-frame, then a good frame
      reset_dut();
      base = wa_q.size();
      beat(8'd0, 1'b1, 1'b0);
      beat(8'd0, 1'b0, 1'b0);
      beat(8'd0, 1'b0, 1'b0);
      good_frame();
      check("rs_nwr",   32'(wa_q.size() - base), 11);
      check("rs_addr3", 32'(wa_q[base+3]), 0);
      check("rs_addr10", 32'(wa_q[base+10]), 7);
      check("rs_err",   32'(bus.frame_error), 1);
      check("rs_vtr",   32'(bus.valid_to_read), 1);
      check("rs_done",  32'(bus.frames_done), 1);
      release_buf();

      // Long frame: no eop by the last pixel
      reset_dut();
      base = wa_q.size();
      for (int i = 0; i < 8; i++) beat(8'd255, i == 0, 1'b0);
      @(negedge clk);
      check("lg_nwr",   32'(wa_q.size() - base), 7);
      check("lg_err",   32'(bus.frame_error), 1);
      check("lg_vtr",   32'(bus.valid_to_read), 0);
      check("lg_ready", 32'(bus.pix_ready), 1);

      // sop+eop together, stray beats in IDLE, gaps and ignored release mid-frame
      reset_dut();
      base = wa_q.size();
      beat(8'd255, 1'b1, 1'b1);
      check("se_err", 32'(bus.frame_error), 1);
      beat(8'd255, 1'b0, 1'b0);
      beat(8'd255, 1'b0, 1'b0);
      @(negedge clk);
      check("gp_idle", 32'(wa_q.size() - base), 0);
      for (int i = 0; i < 8; i++) begin
         beat(pix_tab[i], i == 0, i == 7);
         if (i == 2) release_buf();
         if (i % 2 == 1 && i != 7) repeat (2) @(negedge clk);
      end
      check("gp_nwr", 32'(wa_q.size() - base), 8);
      for (int i = 0; i < 8; i++)
         check($sformatf("gp_addr%0d", i), 32'(wa_q[base+i]), 32'(i));
      check("gp_vtr",  32'(bus.valid_to_read), 1);
      check("gp_done", 32'(bus.frames_done), 1);
      release_buf();

      // Reset asserted while 4th beat is offered
      reset_dut();
      base = wa_q.size();
      beat(8'd0, 1'b1, 1'b0);
      beat(8'd200, 1'b0, 1'b0);
      beat(8'd255, 1'b0, 1'b0);
      bus.pix_valid = 1'b1; bus.pix_data = 8'd255;
      #2 rst_n = 1'b0;
      #1;
      check("mw_we",    32'(bus.bram_we), 0);
      check("mw_waddr", 32'(bus.bram_waddr), 0);
      check("mw_wdata", 32'(bus.bram_wdata), 0);
      bus.pix_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("mw_nostale", 32'(wa_q.size() - base), 3);
      check("mw_ready",   32'(bus.pix_ready), 1);
      good_frame();
      check("mw_vtr", 32'(bus.valid_to_read), 1);

      // Reset during handoff
      base = wa_q.size();
      #2 rst_n = 1'b0;
      #1;
      check("hr_vtr",  32'(bus.valid_to_read), 0);
      check("hr_done", 32'(bus.frames_done), 0);
      check("hr_err",  32'(bus.frame_error), 0);
      check("hr_we",   32'(bus.bram_we), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("hr_ready",   32'(bus.pix_ready), 1);
      check("hr_nostale", 32'(wa_q.size() - base), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
